// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: ROB tag width, opcode encodings, default depth.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_rs_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE_DEF    = 8;
  localparam int RS_IDX_W_DEF   = 3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and the index of the lowest one.
// Latency: combinational.
// Backpressure: none; pure function of the request vector.
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the last hit written is the lowest index
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds micro-ops until operands arrive via CDB snoop, issues lowest ready entry.
// Latency: dispatch-to-issue 1 cycle; wakeup-to-issue 1 cycle, 0 with ALU_RS_WAKEUP_BYPASS_EN defined.
// Backpressure: full stalls dispatch upstream; rdy low freezes all state and the alu_* outputs.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = RS_IDX_W_DEF,
  parameter int ROB_W    = ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic [2:0]       disp_op,
  input  logic [6:0]       disp_type,
  input  logic             disp_op_other,
  input  logic [31:0]      disp_v1,
  input  logic [31:0]      disp_v2,
  input  logic             disp_q1_valid,
  input  logic             disp_q2_valid,
  input  logic [ROB_W-1:0] disp_q1,
  input  logic [ROB_W-1:0] disp_q2,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob_id,
  input  logic [31:0]      cdb_lsb_value,
  output logic             full,
  output logic             alu_valid,
  output logic [ROB_W-1:0] alu_rob_id,
  output logic [2:0]       alu_op,
  output logic [6:0]       alu_type,
  output logic             alu_op_other,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2
);

  // Entry state
  logic [RS_SIZE-1:0] busy_q, busy_d, q1v_q, q1v_d, q2v_q, q2v_d, oth_q, oth_d;
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_d  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_d  [RS_SIZE];
  logic [2:0]         op_q  [RS_SIZE];
  logic [2:0]         op_d  [RS_SIZE];
  logic [6:0]         typ_q [RS_SIZE];
  logic [6:0]         typ_d [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v1_d  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];
  logic [31:0]        v2_d  [RS_SIZE];

  // Issue output registers
  logic             alu_valid_q, alu_valid_d, alu_oth_q, alu_oth_d;
  logic [ROB_W-1:0] alu_rob_q, alu_rob_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [6:0]       alu_typ_q, alu_typ_d;
  logic [31:0]      alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;

  logic [RS_SIZE-1:0]  h1_alu, h1_lsb, h2_alu, h2_lsb, ready_vec;
  logic                free_found, rdy_found;
  logic [RS_IDX_W-1:0] free_idx, rdy_idx;

  // Per-entry tag match against both broadcast buses, and issue readiness
  always_comb begin
    h1_alu    = '0;
    h1_lsb    = '0;
    h2_alu    = '0;
    h2_lsb    = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      h1_alu[i] = cdb_alu_valid && (q1_q[i] == cdb_alu_rob_id);
      h1_lsb[i] = cdb_lsb_valid && (q1_q[i] == cdb_lsb_rob_id);
      h2_alu[i] = cdb_alu_valid && (q2_q[i] == cdb_alu_rob_id);
      h2_lsb[i] = cdb_lsb_valid && (q2_q[i] == cdb_lsb_rob_id);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      // A pending operand being broadcast this cycle counts as available
      ready_vec[i] = busy_q[i]
                   && (!q1v_q[i] || h1_alu[i] || h1_lsb[i])
                   && (!q2v_q[i] || h2_alu[i] || h2_lsb[i]);
`else
      ready_vec[i] = busy_q[i] && !q1v_q[i] && !q2v_q[i];
`endif
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .req   (~busy_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
    .req   (ready_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  // Next state: wakeup capture, then issue, then dispatch, with flush overriding all
  always_comb begin
    busy_d = busy_q;  q1v_d = q1v_q;  q2v_d = q2v_q;  oth_d = oth_q;
    rob_d  = rob_q;   q1_d  = q1_q;   q2_d  = q2_q;
    op_d   = op_q;    typ_d = typ_q;  v1_d  = v1_q;   v2_d = v2_q;
    alu_valid_d = 1'b0;
    alu_rob_d   = alu_rob_q;
    alu_op_d    = alu_op_q;
    alu_typ_d   = alu_typ_q;
    alu_oth_d   = alu_oth_q;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;

    // ALU bus takes precedence when both buses carry the same tag
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && q1v_q[i]) begin
        if (h1_alu[i]) begin
          v1_d[i] = cdb_alu_value; q1v_d[i] = 1'b0;
        end else if (h1_lsb[i]) begin
          v1_d[i] = cdb_lsb_value; q1v_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && q2v_q[i]) begin
        if (h2_alu[i]) begin
          v2_d[i] = cdb_alu_value; q2v_d[i] = 1'b0;
        end else if (h2_lsb[i]) begin
          v2_d[i] = cdb_lsb_value; q2v_d[i] = 1'b0;
        end
      end
    end

    // Issue reads post-capture values so the bypass path sees the broadcast data
    if (rdy_found) begin
      busy_d[rdy_idx] = 1'b0;
      alu_valid_d     = 1'b1;
      alu_rob_d       = rob_q[rdy_idx];
      alu_op_d        = op_q[rdy_idx];
      alu_typ_d       = typ_q[rdy_idx];
      alu_oth_d       = oth_q[rdy_idx];
      alu_v1_d        = v1_d[rdy_idx];
      alu_v2_d        = v2_d[rdy_idx];
    end

    // Free slot comes from pre-edge busy, so it never collides with the issuing entry
    if (disp_valid && free_found) begin
      busy_d[free_idx] = 1'b1;
      rob_d[free_idx]  = disp_rob_id;
      op_d[free_idx]   = disp_op;
      typ_d[free_idx]  = disp_type;
      oth_d[free_idx]  = disp_op_other;
      q1_d[free_idx]   = disp_q1;
      q2_d[free_idx]   = disp_q2;
      v1_d[free_idx]   = disp_v1;
      v2_d[free_idx]   = disp_v2;
      q1v_d[free_idx]  = disp_q1_valid;
      q2v_d[free_idx]  = disp_q2_valid;
      if (disp_q1_valid && cdb_alu_valid && disp_q1 == cdb_alu_rob_id) begin
        v1_d[free_idx] = cdb_alu_value; q1v_d[free_idx] = 1'b0;
      end else if (disp_q1_valid && cdb_lsb_valid && disp_q1 == cdb_lsb_rob_id) begin
        v1_d[free_idx] = cdb_lsb_value; q1v_d[free_idx] = 1'b0;
      end
      if (disp_q2_valid && cdb_alu_valid && disp_q2 == cdb_alu_rob_id) begin
        v2_d[free_idx] = cdb_alu_value; q2v_d[free_idx] = 1'b0;
      end else if (disp_q2_valid && cdb_lsb_valid && disp_q2 == cdb_lsb_rob_id) begin
        v2_d[free_idx] = cdb_lsb_value; q2v_d[free_idx] = 1'b0;
      end
    end

    // Flush drops every entry and cancels this cycle's issue; operand outputs hold
    if (flush) begin
      busy_d      = '0;
      alu_valid_d = 1'b0;
      alu_rob_d   = alu_rob_q;
      alu_op_d    = alu_op_q;
      alu_typ_d   = alu_typ_q;
      alu_oth_d   = alu_oth_q;
      alu_v1_d    = alu_v1_q;
      alu_v2_d    = alu_v2_q;
    end
  end

  // Control and output registers: reset, then hold while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      q1v_q       <= '0;
      q2v_q       <= '0;
      alu_valid_q <= 1'b0;
      alu_rob_q   <= '0;
      alu_op_q    <= '0;
      alu_typ_q   <= '0;
      alu_oth_q   <= 1'b0;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
    end else if (rdy) begin
      busy_q      <= busy_d;
      q1v_q       <= q1v_d;
      q2v_q       <= q2v_d;
      alu_valid_q <= alu_valid_d;
      alu_rob_q   <= alu_rob_d;
      alu_op_q    <= alu_op_d;
      alu_typ_q   <= alu_typ_d;
      alu_oth_q   <= alu_oth_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
    end
  end

  // Entry payload: no reset needed since every field is qualified by busy
  always_ff @(posedge clk) begin
    if (rdy) begin
      rob_q <= rob_d;
      op_q  <= op_d;
      typ_q <= typ_d;
      oth_q <= oth_d;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
    end
  end

  assign full         = &busy_q;
  assign alu_valid    = alu_valid_q;
  assign alu_rob_id   = alu_rob_q;
  assign alu_op       = alu_op_q;
  assign alu_type     = alu_typ_q;
  assign alu_op_other = alu_oth_q;
  assign alu_v1       = alu_v1_q;
  assign alu_v2       = alu_v2_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: table-driven dispatch vectors plus directed wakeup/flush/rdy sequences.
// Latency: expectations follow 1-cycle dispatch-to-issue; wakeup-to-issue adapts to ALU_RS_WAKEUP_BYPASS_EN.
// Backpressure: exercises full and the rdy-low freeze; issues are scored in order through a queue.
module tb_alu_rs;
  import alu_rs_pkg::*;

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk, rst, rdy, flush;
  logic        disp_valid, disp_op_other, disp_q1_valid, disp_q2_valid;
  logic [3:0]  disp_rob_id, disp_q1, disp_q2;
  logic [2:0]  disp_op;
  logic [6:0]  disp_type;
  logic [31:0] disp_v1, disp_v2;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_alu_value, cdb_lsb_value;
  logic        full, alu_valid, alu_op_other;
  logic [3:0]  alu_rob_id;
  logic [2:0]  alu_op;
  logic [6:0]  alu_type;
  logic [31:0] alu_v1, alu_v2;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_rob_id(disp_rob_id), .disp_op(disp_op),
    .disp_type(disp_type), .disp_op_other(disp_op_other),
    .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1_valid(disp_q1_valid), .disp_q2_valid(disp_q2_valid),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .full(full), .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_op(alu_op),
    .alu_type(alu_type), .alu_op_other(alu_op_other), .alu_v1(alu_v1), .alu_v2(alu_v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rob;
    logic [2:0]  op;
    logic [6:0]  typ;
    logic        oth;
    logic [31:0] v1;
    logic [31:0] v2;
  } iss_t;

  typedef struct {
    logic [3:0]  rob;
    logic [2:0]  op;
    logic [6:0]  typ;
    logic        oth;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        q2v;
    logic [3:0]  q2;
    logic        lsb_vld;
    logic [3:0]  lsb_id;
    logic [31:0] lsb_val;
    logic [31:0] exp_v2;
  } vec_t;

  iss_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic live;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // An edge produced a fresh issue only if it was taken with rdy high and out of reset
  always @(posedge clk) live <= rdy && !rst;

  // Scoreboard: every fresh alu_valid strobe must match the oldest expected issue
  always @(negedge clk) begin
    if (live === 1'b1 && alu_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got rob %0d, expected no issue", alu_rob_id);
      end else begin
        iss_t e;
        e = sb.pop_front();
        chk("issue_rob", 32'(alu_rob_id), 32'(e.rob));
        chk("issue_op", 32'(alu_op), 32'(e.op));
        chk("issue_type", 32'(alu_type), 32'(e.typ));
        chk("issue_oth", 32'(alu_op_other), 32'(e.oth));
        chk("issue_v1", alu_v1, e.v1);
        chk("issue_v2", alu_v2, e.v2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] rob, input logic [2:0] op, input logic [6:0] typ,
                      input logic oth, input logic [31:0] v1, input logic [31:0] v2);
    iss_t e;
    e.rob = rob; e.op = op; e.typ = typ; e.oth = oth; e.v1 = v1; e.v2 = v2;
    sb.push_back(e);
  endtask

  task automatic disp(input logic [3:0] rob, input logic [2:0] op, input logic [6:0] typ,
                      input logic oth, input logic [31:0] v1, input logic [31:0] v2,
                      input logic q1v, input logic [3:0] q1, input logic q2v, input logic [3:0] q2);
    disp_valid = 1'b1; disp_rob_id = rob; disp_op = op; disp_type = typ; disp_op_other = oth;
    disp_v1 = v1; disp_v2 = v2; disp_q1_valid = q1v; disp_q1 = q1; disp_q2_valid = q2v; disp_q2 = q2;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic av, input logic [3:0] aid, input logic [31:0] aval,
                     input logic lv, input logic [3:0] lid, input logic [31:0] lval);
    cdb_alu_valid = av; cdb_alu_rob_id = aid; cdb_alu_value = aval;
    cdb_lsb_valid = lv; cdb_lsb_rob_id = lid; cdb_lsb_value = lval;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'd1,  3'd0, OP_IMM,    1'b0, 32'h1,         32'h2,         1'b0, 4'd0, 1'b0, 4'd0, 32'h0,    32'h2};
    vecs[1] = '{4'd2,  3'd0, OP_REG,    1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,    32'h8000_0000};
    vecs[2] = '{4'd6,  3'd5, OP_REG,    1'b1, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'd6, 1'b1, 4'd6, 32'hFF,   32'hFF};
    vecs[3] = '{4'd7,  3'd1, OP_BRANCH, 1'b0, 32'h7,         32'h1234,      1'b0, 4'd7, 1'b1, 4'd7, 32'h5555, 32'h1234};
    vecs[4] = '{4'd15, 3'd7, OP_IMM,    1'b0, 32'h0,         32'h3,         1'b1, 4'd3, 1'b1, 4'd3, 32'h0,    32'h0};
    vecs[5] = '{4'd0,  3'd4, OP_BRANCH, 1'b0, 32'hA5A5,      32'h5A5A,      1'b0, 4'd0, 1'b0, 4'd0, 32'h0,    32'h5A5A};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    disp_rob_id = '0; disp_op = '0; disp_type = '0; disp_op_other = 1'b0;
    disp_v1 = '0; disp_v2 = '0; disp_q1_valid = 1'b0; disp_q2_valid = 1'b0; disp_q1 = '0; disp_q2 = '0;
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

    // Reset state
    step(); step(); step();
    rst = 1'b0;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_rob", 32'(alu_rob_id), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_type", 32'(alu_type), 32'd0);
    chk("rst_oth", 32'(alu_op_other), 32'd0);
    chk("rst_v1", alu_v1, 32'd0);
    chk("rst_v2", alu_v2, 32'd0);

    // Basic add: issue exactly one cycle after dispatch, one-cycle strobe
    push(4'd3, 3'd0, OP_REG, 1'b0, 32'd5, 32'd7);
    disp(4'd3, 3'd0, OP_REG, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("add_e0_valid", 32'(alu_valid), 32'd0);
    step();
    chk("add_e1_valid", 32'(alu_valid), 32'd1);
    step();
    chk("add_e2_valid", 32'(alu_valid), 32'd0);

    // Table: back-to-back dispatch, some with same-cycle LSB capture
    for (int k = 0; k < 6; k++) begin
      push(vecs[k].rob, vecs[k].op, vecs[k].typ, vecs[k].oth, vecs[k].v1, vecs[k].exp_v2);
      cdb(1'b0, 4'd0, 32'h0, vecs[k].lsb_vld, vecs[k].lsb_id, vecs[k].lsb_val);
      disp(vecs[k].rob, vecs[k].op, vecs[k].typ, vecs[k].oth, vecs[k].v1, vecs[k].v2,
           1'b0, 4'd0, vecs[k].q2v, vecs[k].q2);
      cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    end
    step(); step();
    chk("table_drained", 32'(sb.size()), 32'd0);

    // Deferred wakeup from ALU bus two cycles after dispatch
    push(4'd4, 3'd0, OP_REG, 1'b0, 32'h10, 32'd9);
    disp(4'd4, 3'd0, OP_REG, 1'b0, 32'h0, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0);
    chk("wake_e0_valid", 32'(alu_valid), 32'd0);
    step();
    chk("wake_e1_valid", 32'(alu_valid), 32'd0);
    cdb(1'b1, 4'd2, 32'h10, 1'b0, 4'd0, 32'h0);
    step();
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("wake_e2_valid", 32'(alu_valid), 32'(BYP));
    step();
    chk("wake_e3_valid", 32'(alu_valid), 32'(!BYP));
    step();

    // Fill all 8 entries pending on tags 0..7
    for (int i = 0; i < 8; i++) begin
      disp(4'(8 + i), 3'd0, OP_REG, 1'b0, 32'h0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0);
      if (i == 6) chk("fill_not_full", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_no_issue", 32'(alu_valid), 32'd0);
    push(4'd10, 3'd0, OP_REG, 1'b0, 32'h22, 32'd2);
    push(4'd13, 3'd0, OP_REG, 1'b0, 32'h55, 32'd5);
    cdb(1'b1, 4'd5, 32'h55, 1'b1, 4'd2, 32'h22);
    step();
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("dual_w_full", 32'(full), 32'(!BYP));
    chk("dual_w_valid", 32'(alu_valid), 32'(BYP));
    step();
    chk("dual_w1_valid", 32'(alu_valid), 32'd1);
    chk("dual_w1_full", 32'(full), 32'd0);
    step();
    chk("dual_w2_valid", 32'(alu_valid), 32'(!BYP));
    step();
    chk("dual_w3_valid", 32'(alu_valid), 32'd0);

    // Flush with simultaneous dispatch and a wakeup: nothing survives
    flush = 1'b1;
    cdb(1'b1, 4'd0, 32'h1, 1'b0, 4'd0, 32'h0);
    disp(4'd1, 3'd0, OP_IMM, 1'b0, 32'h1, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b0;
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("flush_valid", 32'(alu_valid), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_rob_hold", 32'(alu_rob_id), 32'd13);
    cdb(1'b1, 4'd1, 32'h1, 1'b1, 4'd3, 32'h3);
    step();
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step(); step();
    chk("flush_stale_valid", 32'(alu_valid), 32'd0);

    // rdy low for 3 cycles during a pending broadcast: frozen, no capture
    push(4'd6, 3'd2, OP_IMM, 1'b0, 32'h66, 32'h77);
    push(4'd5, 3'd0, OP_REG, 1'b0, 32'h1, 32'hCD);
    disp(4'd5, 3'd0, OP_REG, 1'b0, 32'h1, 32'h0, 1'b0, 4'd0, 1'b1, 4'd9);
    disp(4'd6, 3'd2, OP_IMM, 1'b0, 32'h66, 32'h77, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("rdy_pre_valid", 32'(alu_valid), 32'd0);
    step();
    chk("rdy_issue_valid", 32'(alu_valid), 32'd1);
    rdy = 1'b0;
    cdb(1'b1, 4'd9, 32'hAB, 1'b0, 4'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("frz_valid", 32'(alu_valid), 32'd1);
      chk("frz_rob", 32'(alu_rob_id), 32'd6);
      chk("frz_v1", alu_v1, 32'h66);
    end
    rdy = 1'b1;
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    chk("resume_valid", 32'(alu_valid), 32'd0);
    cdb(1'b1, 4'd9, 32'hCD, 1'b0, 4'd0, 32'h0);
    step();
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("resume_w_valid", 32'(alu_valid), 32'(BYP));
    step();
    chk("resume_w1_valid", 32'(alu_valid), 32'(!BYP));
    step();

    // Same tag on both buses for both operands: ALU bus value wins
    push(4'd3, 3'd6, OP_REG, 1'b0, 32'h1111, 32'h1111);
    disp(4'd3, 3'd6, OP_REG, 1'b0, 32'h0, 32'h0, 1'b1, 4'd10, 1'b1, 4'd10);
    cdb(1'b1, 4'd10, 32'h1111, 1'b1, 4'd10, 32'h2222);
    step();
    cdb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step(); step(); step();
    chk("end_drained", 32'(sb.size()), 32'd0);
    chk("end_valid", 32'(alu_valid), 32'd0);
    chk("end_full", 32'(full), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
